// File: rtl/pla_id_seq_chk_mc_pkg.sv
// Shared types and helpers for the multi-channel slice-ID sequence checker.
package pla_seq_pkg;

  typedef enum logic [2:0] {
    SEQ_INORD,
    SEQ_LOSS,
    SEQ_DUP,
    SEQ_OOO,
    SEQ_SYNC
  } seq_class_e;

  localparam int unsigned SAT_ARG_W = 32;

  // Saturating add clamped to 2^w-1; w is the counter width of the caller (<= 32).
  function automatic logic [SAT_ARG_W-1:0] sat_add(input logic [SAT_ARG_W-1:0] a,
                                                   input logic [SAT_ARG_W-1:0] b,
                                                   input int unsigned w);
    logic [SAT_ARG_W:0] sum;
    logic [SAT_ARG_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[SAT_ARG_W-1:0] : sum[SAT_ARG_W-1:0];
  endfunction

endpackage

// File: rtl/pla_id_seq_chk_mc_classify.sv
// Combinational slice classification: modular ID delta, class, last-ID update and resync decision.
module pla_seq_classify
  import pla_seq_pkg::*;
#(
  parameter int unsigned ID_W      = 15,
  parameter int unsigned LOSS_WIN  = 1024,
  parameter int unsigned RESYNC_TH = 4,
  parameter int unsigned RUN_W     = 3
) (
  input  logic [ID_W-1:0]  id,
  input  logic [ID_W-1:0]  last_id,
  input  logic             synced,
  input  logic [RUN_W-1:0] ooo_run,
  output seq_class_e       cls_c,
  output logic [ID_W-1:0]  delta_c,
  output logic             upd_last_c,
  output logic [RUN_W-1:0] run_nxt_c,
  output logic             resync_c
);

  logic [RUN_W-1:0] run_inc;

  always_comb begin
    delta_c    = id - last_id;
    run_inc    = ooo_run + RUN_W'(1);
    cls_c      = SEQ_OOO;
    upd_last_c = 1'b0;
    run_nxt_c  = ooo_run;
    resync_c   = 1'b0;
    if (!synced) begin
      cls_c      = SEQ_SYNC;
      upd_last_c = 1'b1;
      run_nxt_c  = '0;
    end else if (delta_c == ID_W'(1)) begin
      cls_c      = SEQ_INORD;
      upd_last_c = 1'b1;
      run_nxt_c  = '0;
    end else if (delta_c == ID_W'(0)) begin
      cls_c      = SEQ_DUP;
    end else if (32'(delta_c) <= 32'(LOSS_WIN)) begin
      cls_c      = SEQ_LOSS;
      upd_last_c = 1'b1;
      run_nxt_c  = '0;
    end else begin
      // Backward or far-forward jump; a run of these re-anchors the channel.
      cls_c = SEQ_OOO;
      if (32'(run_inc) == 32'(RESYNC_TH)) begin
        upd_last_c = 1'b1;
        run_nxt_c  = '0;
        resync_c   = 1'b1;
      end else begin
        run_nxt_c  = run_inc;
      end
    end
  end

endmodule

// File: rtl/pla_id_seq_chk_mc.sv
// Multi-channel slice-ID sequence checker: per-channel ID tracking, loss/dup/OOO events and statistics.
module pla_id_seq_chk_mc
  import pla_seq_pkg::*;
#(
  parameter int unsigned CHN_NUM   = 8,
  parameter int unsigned ID_W      = 15,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned LOSS_WIN  = 1024,
  parameter int unsigned RESYNC_TH = 4,
  parameter logic [15:0] MARKER    = 16'h55D5,
  localparam int unsigned CHN_W    = (CHN_NUM > 1) ? $clog2(CHN_NUM) : 1
) (
  input  logic               I_pla_312m5_clk,
  input  logic               I_pla_rst,
  input  logic               I_pla_slice_en,
  input  logic [CHN_W-1:0]   I_pla_slice_chn,
  input  logic [ID_W-1:0]    I_pla_slice_id,
  input  logic [31:0]        I_pla_slice_payload,
  input  logic               I_cnt_clear,
  input  logic [CHN_W-1:0]   I_stat_chn,
  output logic               O_slice_lose_reg,
  output logic               O_slice_dup_reg,
  output logic               O_slice_ooo_reg,
  output logic [CHN_W-1:0]   O_event_chn,
  output logic [CNT_W-1:0]   O_slice_55D5_cnt,
  output logic [CNT_W-1:0]   O_slice_lose_cnt,
  output logic [CNT_W-1:0]   O_slice_dup_cnt,
  output logic [CNT_W-1:0]   O_slice_ooo_cnt,
  output logic [CNT_W-1:0]   O_resync_cnt,
  output logic [CHN_NUM-1:0] O_chn_synced
);

  localparam int unsigned RUN_W = $clog2(RESYNC_TH + 1);

  logic             en_d1;
  logic             en_hold;
  logic             chn_ok_c;
  logic             stat_ok_c;
  logic [CHN_W-1:0] chn_idx_c;
  logic [CHN_W-1:0] stat_idx_c;
  logic             start_c;
  logic             ev_c;
  logic             mark_hit_c;

  logic [ID_W-1:0]  last_id  [CHN_NUM];
  logic [RUN_W-1:0] ooo_run  [CHN_NUM];
  logic [CNT_W-1:0] lose_cnt [CHN_NUM];
  logic [CNT_W-1:0] dup_cnt  [CHN_NUM];
  logic [CNT_W-1:0] ooo_cnt  [CHN_NUM];
  logic [CNT_W-1:0] rsy_cnt  [CHN_NUM];

  seq_class_e       cls_c;
  logic [ID_W-1:0]  delta_c;
  logic [ID_W-1:0]  lose_inc_c;
  logic             upd_last_c;
  logic [RUN_W-1:0] run_nxt_c;
  logic             resync_c;

  // Channel range checks only exist when CHN_NUM leaves unused codes.
  generate
    if (CHN_NUM == (1 << CHN_W)) begin : g_chn_full
      assign chn_ok_c  = 1'b1;
      assign stat_ok_c = 1'b1;
    end else begin : g_chn_part
      assign chn_ok_c  = (32'(I_pla_slice_chn) < CHN_NUM);
      assign stat_ok_c = (32'(I_stat_chn) < CHN_NUM);
    end
  endgenerate

  // en_hold masks an enable that is still high when reset is released.
  assign chn_idx_c  = chn_ok_c ? I_pla_slice_chn : '0;
  assign stat_idx_c = stat_ok_c ? I_stat_chn : '0;
  assign start_c    = I_pla_slice_en & ~en_d1 & ~en_hold & chn_ok_c & ~I_cnt_clear;
  assign ev_c       = (cls_c == SEQ_LOSS) | (cls_c == SEQ_DUP) | (cls_c == SEQ_OOO);
  assign mark_hit_c = I_pla_slice_en & ((I_pla_slice_payload[15:0] == MARKER) |
                                        (I_pla_slice_payload[31:16] == MARKER));
  assign lose_inc_c = delta_c - ID_W'(1);

  pla_seq_classify #(
    .ID_W      (ID_W),
    .LOSS_WIN  (LOSS_WIN),
    .RESYNC_TH (RESYNC_TH),
    .RUN_W     (RUN_W)
  ) u_classify (
    .id         (I_pla_slice_id),
    .last_id    (last_id[chn_idx_c]),
    .synced     (O_chn_synced[chn_idx_c]),
    .ooo_run    (ooo_run[chn_idx_c]),
    .cls_c      (cls_c),
    .delta_c    (delta_c),
    .upd_last_c (upd_last_c),
    .run_nxt_c  (run_nxt_c),
    .resync_c   (resync_c)
  );

  // Start detection, event pulses and the global marker counter.
  always_ff @(posedge I_pla_312m5_clk or posedge I_pla_rst) begin
    if (I_pla_rst) begin
      en_d1            <= 1'b0;
      en_hold          <= 1'b1;
      O_slice_lose_reg <= 1'b0;
      O_slice_dup_reg  <= 1'b0;
      O_slice_ooo_reg  <= 1'b0;
      O_event_chn      <= '0;
      O_slice_55D5_cnt <= '0;
    end else begin
      en_d1 <= I_pla_slice_en;
      if (!I_pla_slice_en) begin
        en_hold <= 1'b0;
      end
      O_slice_lose_reg <= start_c & (cls_c == SEQ_LOSS);
      O_slice_dup_reg  <= start_c & (cls_c == SEQ_DUP);
      O_slice_ooo_reg  <= start_c & (cls_c == SEQ_OOO);
      if (start_c && ev_c) begin
        O_event_chn <= I_pla_slice_chn;
      end
      if (I_cnt_clear) begin
        O_slice_55D5_cnt <= '0;
      end else if (mark_hit_c) begin
        O_slice_55D5_cnt <= CNT_W'(sat_add(32'(O_slice_55D5_cnt), 32'd1, CNT_W));
      end
    end
  end

  // Per-channel sequence table; clear keeps last_id so the next slice re-syncs.
  always_ff @(posedge I_pla_312m5_clk or posedge I_pla_rst) begin
    if (I_pla_rst) begin
      O_chn_synced <= '0;
      for (int i = 0; i < CHN_NUM; i++) begin
        last_id[i] <= '1;
        ooo_run[i] <= '0;
      end
    end else if (I_cnt_clear) begin
      O_chn_synced <= '0;
      for (int i = 0; i < CHN_NUM; i++) begin
        ooo_run[i] <= '0;
      end
    end else if (start_c) begin
      O_chn_synced[chn_idx_c] <= 1'b1;
      ooo_run[chn_idx_c]      <= run_nxt_c;
      if (upd_last_c) begin
        last_id[chn_idx_c] <= I_pla_slice_id;
      end
    end
  end

  // Per-channel saturating statistics.
  always_ff @(posedge I_pla_312m5_clk or posedge I_pla_rst) begin
    if (I_pla_rst) begin
      for (int i = 0; i < CHN_NUM; i++) begin
        lose_cnt[i] <= '0;
        dup_cnt[i]  <= '0;
        ooo_cnt[i]  <= '0;
        rsy_cnt[i]  <= '0;
      end
    end else if (I_cnt_clear) begin
      for (int i = 0; i < CHN_NUM; i++) begin
        lose_cnt[i] <= '0;
        dup_cnt[i]  <= '0;
        ooo_cnt[i]  <= '0;
        rsy_cnt[i]  <= '0;
      end
    end else if (start_c) begin
      case (cls_c)
        SEQ_LOSS: lose_cnt[chn_idx_c] <= CNT_W'(sat_add(32'(lose_cnt[chn_idx_c]), 32'(lose_inc_c), CNT_W));
        SEQ_DUP:  dup_cnt[chn_idx_c]  <= CNT_W'(sat_add(32'(dup_cnt[chn_idx_c]), 32'd1, CNT_W));
        SEQ_OOO: begin
          ooo_cnt[chn_idx_c] <= CNT_W'(sat_add(32'(ooo_cnt[chn_idx_c]), 32'd1, CNT_W));
          if (resync_c) begin
            rsy_cnt[chn_idx_c] <= CNT_W'(sat_add(32'(rsy_cnt[chn_idx_c]), 32'd1, CNT_W));
          end
        end
        default: ;
      endcase
    end
  end

  // Registered statistics readout for the selected channel.
  always_ff @(posedge I_pla_312m5_clk or posedge I_pla_rst) begin
    if (I_pla_rst) begin
      O_slice_lose_cnt <= '0;
      O_slice_dup_cnt  <= '0;
      O_slice_ooo_cnt  <= '0;
      O_resync_cnt     <= '0;
    end else begin
      O_slice_lose_cnt <= stat_ok_c ? lose_cnt[stat_idx_c] : '0;
      O_slice_dup_cnt  <= stat_ok_c ? dup_cnt[stat_idx_c]  : '0;
      O_slice_ooo_cnt  <= stat_ok_c ? ooo_cnt[stat_idx_c]  : '0;
      O_resync_cnt     <= stat_ok_c ? rsy_cnt[stat_idx_c]  : '0;
    end
  end

endmodule

// File: tb/tb_pla_id_seq_chk_mc.sv
// Self-checking bench for pla_id_seq_chk_mc: directed scenarios plus randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_pla_id_seq_chk_mc;

  localparam int unsigned NCH     = 8;
  localparam int unsigned ID_MASK = 32'h7FFF;
  localparam int unsigned MAX_CNT = 65535;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  chn = '0;
  logic [14:0] id = '0;
  logic [31:0] pay = '0;
  logic        clr = 1'b0;
  logic [2:0]  stat = '0;

  logic        o_lose, o_dup, o_ooo;
  logic [2:0]  o_evc;
  logic [15:0] o_mark, o_lcnt, o_dcnt, o_ocnt, o_rcnt;
  logic [7:0]  o_sync;

  logic        d2_lose, d2_dup, d2_ooo;
  logic [2:0]  d2_evc;
  logic [15:0] d2_mark, d2_lcnt, d2_dcnt, d2_ocnt, d2_rcnt;
  logic [5:0]  d2_sync;

  always #5 clk = ~clk;

  pla_id_seq_chk_mc dut (
    .I_pla_312m5_clk(clk), .I_pla_rst(rst), .I_pla_slice_en(en), .I_pla_slice_chn(chn),
    .I_pla_slice_id(id), .I_pla_slice_payload(pay), .I_cnt_clear(clr), .I_stat_chn(stat),
    .O_slice_lose_reg(o_lose), .O_slice_dup_reg(o_dup), .O_slice_ooo_reg(o_ooo),
    .O_event_chn(o_evc), .O_slice_55D5_cnt(o_mark), .O_slice_lose_cnt(o_lcnt),
    .O_slice_dup_cnt(o_dcnt), .O_slice_ooo_cnt(o_ocnt), .O_resync_cnt(o_rcnt),
    .O_chn_synced(o_sync)
  );

  pla_id_seq_chk_mc #(.CHN_NUM(6)) dut2 (
    .I_pla_312m5_clk(clk), .I_pla_rst(rst), .I_pla_slice_en(en), .I_pla_slice_chn(chn),
    .I_pla_slice_id(id), .I_pla_slice_payload(pay), .I_cnt_clear(clr), .I_stat_chn(stat),
    .O_slice_lose_reg(d2_lose), .O_slice_dup_reg(d2_dup), .O_slice_ooo_reg(d2_ooo),
    .O_event_chn(d2_evc), .O_slice_55D5_cnt(d2_mark), .O_slice_lose_cnt(d2_lcnt),
    .O_slice_dup_cnt(d2_dcnt), .O_slice_ooo_cnt(d2_ocnt), .O_resync_cnt(d2_rcnt),
    .O_chn_synced(d2_sync)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state, one entry per channel.
  int unsigned m_last [NCH];
  int unsigned m_sync [NCH];
  int unsigned m_run  [NCH];
  int unsigned m_lose [NCH];
  int unsigned m_dup  [NCH];
  int unsigned m_ooo  [NCH];
  int unsigned m_rsy  [NCH];
  int unsigned m_mark;

  logic [2:0] ex_p;
  int         ex_c;
  logic [2:0] ob_p;
  logic [2:0] ob_c;
  logic       ob_after;
  logic       d2_any;

  function automatic int unsigned sat(input int unsigned a, input int unsigned b);
    longint unsigned s;
    s = longint'(a) + longint'(b);
    return (s > MAX_CNT) ? MAX_CNT : int'(s);
  endfunction

  function automatic bit hit(input logic [31:0] p);
    return (p[15:0] == 16'h55D5) || (p[31:16] == 16'h55D5);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_last[i] = ID_MASK; m_sync[i] = 0; m_run[i] = 0;
      m_lose[i] = 0; m_dup[i] = 0; m_ooo[i] = 0; m_rsy[i] = 0;
    end
    m_mark = 0;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NCH; i++) begin
      m_sync[i] = 0; m_run[i] = 0;
      m_lose[i] = 0; m_dup[i] = 0; m_ooo[i] = 0; m_rsy[i] = 0;
    end
    m_mark = 0;
  endfunction

  // Expected pulses {lose,dup,ooo} for one slice start, and the resulting state.
  function automatic void model_start(input int c, input int unsigned sid);
    int unsigned d;
    d = (sid - m_last[c]) & ID_MASK;
    ex_p = 3'b000;
    ex_c = c;
    if (m_sync[c] == 0) begin
      m_sync[c] = 1; m_last[c] = sid;
    end else if (d == 1) begin
      m_last[c] = sid; m_run[c] = 0;
    end else if (d == 0) begin
      ex_p = 3'b010; m_dup[c] = sat(m_dup[c], 1);
    end else if (d <= 1024) begin
      ex_p = 3'b100; m_lose[c] = sat(m_lose[c], d - 1); m_last[c] = sid; m_run[c] = 0;
    end else begin
      ex_p = 3'b001; m_ooo[c] = sat(m_ooo[c], 1); m_run[c] = m_run[c] + 1;
      if (m_run[c] == 4) begin
        m_last[c] = sid; m_run[c] = 0; m_rsy[c] = sat(m_rsy[c], 1);
      end
    end
  endfunction

  // Drive one slice (len enable cycles, then one idle cycle) and capture observed pulses.
  task automatic slice(input int c, input int unsigned sid, input logic [31:0] p,
                       input int len, input logic clr_start);
    en = 1'b1; chn = c[2:0]; id = sid[14:0]; pay = p; clr = clr_start;
    if (clr_start) begin
      model_clear(); ex_p = 3'b000; ex_c = c;
    end else begin
      if (c < NCH) model_start(c, sid);
      if (hit(p)) m_mark = sat(m_mark, 1);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    ob_p = {o_lose, o_dup, o_ooo};
    ob_c = o_evc;
    d2_any = d2_lose | d2_dup | d2_ooo;
    for (int k = 1; k < len; k++) begin
      if (hit(p)) m_mark = sat(m_mark, 1);
      @(posedge clk); #1;
    end
    en = 1'b0;
    @(posedge clk); #1;
    ob_after = o_lose | o_dup | o_ooo;
  endtask

  task automatic read_stats(input int c);
    stat = c[2:0];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_lose, o_dup, o_ooo, o_evc} !== 6'd0) begin
      failures++; $display("FAIL reset_pulses act=%b exp=0", {o_lose, o_dup, o_ooo, o_evc});
    end
    checks++;
    if ({o_mark, o_lcnt, o_dcnt, o_ocnt, o_rcnt} !== 80'd0) begin
      failures++; $display("FAIL reset_counts act=%h exp=0", {o_mark, o_lcnt, o_dcnt, o_ocnt, o_rcnt});
    end
    checks++;
    if (o_sync !== 8'd0) begin
      failures++; $display("FAIL reset_synced act=%b exp=0", o_sync);
    end
  endtask

  task automatic test_inorder();
    for (int i = 5; i <= 7; i++) begin
      slice(0, i, 32'd0, 1, 1'b0);
      checks++;
      if (ob_p !== 3'b000) begin
        failures++; $display("FAIL inorder_pulse id=%0d act=%b exp=000", i, ob_p);
      end
    end
    read_stats(0);
    checks++;
    if (o_sync[0] !== 1'b1) begin
      failures++; $display("FAIL inorder_synced act=%b exp=1", o_sync[0]);
    end
    checks++;
    if ({o_lcnt, o_dcnt, o_ocnt} !== 48'd0) begin
      failures++; $display("FAIL inorder_cnts act=%h exp=0", {o_lcnt, o_dcnt, o_ocnt});
    end
  endtask

  task automatic test_loss();
    slice(1, 10, 32'd0, 2, 1'b0);
    slice(1, 11, 32'd0, 1, 1'b0);
    slice(1, 15, 32'd0, 1, 1'b0);
    checks++;
    if (ob_p !== 3'b100 || ob_c !== 3'd1) begin
      failures++; $display("FAIL loss_pulse act=%b/%0d exp=100/1", ob_p, ob_c);
    end
    read_stats(1);
    checks++;
    if (o_lcnt !== 16'd3) begin
      failures++; $display("FAIL loss_cnt act=%0d exp=3", o_lcnt);
    end
    read_stats(0);
    checks++;
    if ({o_lcnt, o_dcnt, o_ocnt} !== 48'd0) begin
      failures++; $display("FAIL loss_ch0_cnts act=%h exp=0", {o_lcnt, o_dcnt, o_ocnt});
    end
  endtask

  task automatic test_wrap_dup();
    int unsigned ids [5] = '{32'h7FFE, 32'h7FFF, 0, 1, 1};
    logic [2:0]  exp [5] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010};
    for (int i = 0; i < 5; i++) begin
      slice(2, ids[i], 32'd0, 1, 1'b0);
      checks++;
      if (ob_p !== exp[i] || (exp[i] != 0 && ob_c !== 3'd2)) begin
        failures++; $display("FAIL wrap_dup_pulse step=%0d act=%b/%0d exp=%b/2", i, ob_p, ob_c, exp[i]);
      end
    end
    read_stats(2);
    checks++;
    if (o_dcnt !== 16'd1 || o_lcnt !== 16'd0) begin
      failures++; $display("FAIL wrap_dup_cnt act=dup%0d/lose%0d exp=dup1/lose0", o_dcnt, o_lcnt);
    end
  endtask

  task automatic test_ooo_resync();
    int unsigned ids [7] = '{100, 101, 50, 51, 52, 53, 54};
    logic [2:0]  exp [7] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
    for (int i = 0; i < 7; i++) begin
      slice(3, ids[i], 32'd0, 1, 1'b0);
      checks++;
      if (ob_p !== exp[i] || (exp[i] != 0 && ob_c !== 3'd3)) begin
        failures++; $display("FAIL ooo_pulse step=%0d act=%b/%0d exp=%b/3", i, ob_p, ob_c, exp[i]);
      end
    end
    read_stats(3);
    checks++;
    if (o_ocnt !== 16'd4 || o_rcnt !== 16'd1) begin
      failures++; $display("FAIL ooo_cnts act=ooo%0d/rsy%0d exp=ooo4/rsy1", o_ocnt, o_rcnt);
    end
  endtask

  task automatic test_marker_clear();
    slice(0, 8, 32'h55D555D5, 3, 1'b0);
    slice(0, 9, 32'h000055D5, 1, 1'b0);
    checks++;
    if (o_mark !== 16'd4) begin
      failures++; $display("FAIL marker_cnt act=%0d exp=4", o_mark);
    end
    clr = 1'b1; model_clear();
    @(posedge clk); #1 clr = 1'b0;
    read_stats(1);
    checks++;
    if ({o_mark, o_lcnt} !== 32'd0 || o_sync !== 8'd0) begin
      failures++; $display("FAIL clear_all act=mark%0d/lose%0d/sync%b exp=0/0/0", o_mark, o_lcnt, o_sync);
    end
    slice(0, 10, 32'h000055D5, 1, 1'b1);
    checks++;
    if (ob_p !== 3'b000 || o_mark !== 16'd0 || o_sync !== 8'd0) begin
      failures++; $display("FAIL clear_vs_start act=%b/mark%0d/sync%b exp=000/0/0", ob_p, o_mark, o_sync);
    end
  endtask

  task automatic test_saturate_chn();
    int unsigned cur;
    logic [5:0]  exp_d2;
    clr = 1'b1; model_clear();
    @(posedge clk); #1 clr = 1'b0;
    cur = 0;
    slice(4, cur, 32'd0, 1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      cur = (cur + 1024) & ID_MASK;
      slice(4, cur, 32'd0, 1, 1'b0);
    end
    cur = (cur + 63) & ID_MASK;
    slice(4, cur, 32'd0, 1, 1'b0);
    read_stats(4);
    checks++;
    if (o_lcnt !== 16'hFFFE) begin
      failures++; $display("FAIL sat_pre act=%h exp=FFFE", o_lcnt);
    end
    cur = (cur + 10) & ID_MASK;
    slice(4, cur, 32'd0, 1, 1'b0);
    checks++;
    if (ob_p !== 3'b100) begin
      failures++; $display("FAIL sat_pulse act=%b exp=100", ob_p);
    end
    read_stats(4);
    checks++;
    if (o_lcnt !== 16'hFFFF) begin
      failures++; $display("FAIL sat_clamp act=%h exp=FFFF", o_lcnt);
    end
    exp_d2 = 6'b010000;
    slice(6, 3, 32'd0, 1, 1'b0);
    slice(6, 3, 32'd0, 1, 1'b0);
    checks++;
    if (ob_p !== 3'b010 || d2_any !== 1'b0) begin
      failures++; $display("FAIL chn_range_pulse act=%b/%b exp=010/0", ob_p, d2_any);
    end
    checks++;
    if (d2_sync !== exp_d2 || o_sync[6] !== 1'b1) begin
      failures++; $display("FAIL chn_range_sync act=%b/%b exp=%b/1", d2_sync, o_sync[6], exp_d2);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned sid;
    int          c, mode;
    logic [31:0] p;
    for (int n = 0; n < 300; n++) begin
      c = $urandom_range(0, NCH - 1);
      mode = $urandom_range(0, 9);
      if (mode < 5)       sid = (m_last[c] + 1) & ID_MASK;
      else if (mode == 5) sid = m_last[c];
      else if (mode < 8)  sid = (m_last[c] + $urandom_range(2, 1100)) & ID_MASK;
      else                sid = $urandom & ID_MASK;
      p = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) p[15:0] = 16'h55D5;
        else                           p[31:16] = 16'h55D5;
      end
      slice(c, sid, p, $urandom_range(1, 2), 1'b0);
      checks++;
      if (ob_p !== ex_p || (ex_p != 0 && ob_c !== 3'(ex_c)) || ob_after !== 1'b0) begin
        failures++;
        $display("FAIL rand_pulse n=%0d ch=%0d id=%h act=%b/%0d/%b exp=%b/%0d/0",
                 n, c, sid, ob_p, ob_c, ob_after, ex_p, ex_c);
      end
    end
    for (int c2 = 0; c2 < NCH; c2++) begin
      read_stats(c2);
      checks++;
      if (o_lcnt !== 16'(m_lose[c2]) || o_dcnt !== 16'(m_dup[c2]) ||
          o_ocnt !== 16'(m_ooo[c2]) || o_rcnt !== 16'(m_rsy[c2])) begin
        failures++;
        $display("FAIL rand_stats ch=%0d act=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", c2,
                 o_lcnt, o_dcnt, o_ocnt, o_rcnt, m_lose[c2], m_dup[c2], m_ooo[c2], m_rsy[c2]);
      end
      checks++;
      if (o_sync[c2] !== 1'(m_sync[c2])) begin
        failures++; $display("FAIL rand_synced ch=%0d act=%b exp=%0d", c2, o_sync[c2], m_sync[c2]);
      end
    end
    checks++;
    if (o_mark !== 16'(m_mark)) begin
      failures++; $display("FAIL rand_marker act=%0d exp=%0d", o_mark, m_mark);
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; chn = 3'd5; id = 15'd7; pay = 32'h55D50000;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if (o_sync !== 8'd0 || o_mark !== 16'd0 || {o_lose, o_dup, o_ooo} !== 3'b000) begin
      failures++; $display("FAIL rst_mid_async act=sync%b/mark%0d exp=0/0", o_sync, o_mark);
    end
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_lose, o_dup, o_ooo} !== 3'b000 || o_sync !== 8'd0) begin
      failures++; $display("FAIL rst_mid_no_start act=%b/sync%b exp=000/0", {o_lose, o_dup, o_ooo}, o_sync);
    end
    en = 1'b0;
    @(posedge clk); #1;
    slice(5, 20, 32'd0, 1, 1'b0);
    slice(5, 22, 32'd0, 1, 1'b0);
    checks++;
    if (ob_p !== 3'b100 || o_sync[5] !== 1'b1) begin
      failures++; $display("FAIL rst_mid_recover act=%b/%b exp=100/1", ob_p, o_sync[5]);
    end
  endtask

  initial begin
    test_reset();
    test_inorder();
    test_loss();
    test_wrap_dup();
    test_ooo_resync();
    test_marker_clear();
    test_saturate_chn();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
